// File: rtl/nor_gate.sv
// Three-operand bitwise NOR with a combinational output and an enable-qualified
// registered copy carrying valid, change-detect and a saturating all-ones count.
module nor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] p_reg,
    output logic             valid,
    output logic             changed,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [WIDTH-1:0] nor3(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        return ~(a | b | c);
    endfunction

    // Counter sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] res_p0;
    logic             hit_p0;
    logic [WIDTH-1:0] p_reg_p1;
    logic             vld_p1;
    logic             chg_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Stage 0: combinational result, shared by p and the capture path
    always_comb begin
        res_p0 = nor3(x, y, z);
        hit_p0 = (res_p0 == ONES);
    end

    // Stage 1: enable-qualified capture; reset wins over en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_reg_p1 <= '0;
            vld_p1   <= 1'b0;
            chg_p1   <= 1'b0;
            cnt_p1   <= '0;
        end else if (en) begin
            p_reg_p1 <= res_p0;
            vld_p1   <= 1'b1;
            chg_p1   <= vld_p1 && (res_p0 != p_reg_p1);
            if (hit_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end else begin
            chg_p1 <= 1'b0;
        end
    end

    assign p         = res_p0;
    assign p_reg     = p_reg_p1;
    assign valid     = vld_p1;
    assign changed   = chg_p1;
    assign hit_count = cnt_p1;

endmodule

// File: tb/tb_nor_gate.sv
// Scoreboard bench for nor_gate: a 1-lane instance (CNT_W=8) and a 4-lane
// instance (CNT_W=2) driven by directed vectors with hand-computed results.
module tb_nor_gate;

    typedef struct {
        int         sel;
        logic [3:0] p;
        logic [3:0] p_reg;
        logic       valid;
        logic       changed;
        logic [7:0] hit;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1 = 1'b0, en1 = 1'b0;
    logic [0:0] x1 = '0, y1 = '0, z1 = '0;
    logic [0:0] p1, preg1;
    logic       v1, c1;
    logic [7:0] h1;

    logic       rst4 = 1'b0, en4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0, z4 = '0;
    logic [3:0] p4, preg4;
    logic       v4, c4;
    logic [1:0] h4;

    nor_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst1), .en(en1), .x(x1), .y(y1), .z(z1),
        .p(p1), .p_reg(preg1), .valid(v1), .changed(c1), .hit_count(h1)
    );

    nor_gate #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst4), .en(en4), .x(x4), .y(y4), .z(z4),
        .p(p4), .p_reg(preg4), .valid(v4), .changed(c4), .hit_count(h4)
    );

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int popped = 0;
    int pushed = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: 3 time units after each edge, compare against the oldest expectation
    always @(posedge clk) begin
        #3;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            popped++;
            if (e.sel == 1) begin
                chk({e.name, ".p"},       {7'd0, p1},    {7'd0, e.p[0]});
                chk({e.name, ".p_reg"},   {7'd0, preg1}, {7'd0, e.p_reg[0]});
                chk({e.name, ".valid"},   {7'd0, v1},    {7'd0, e.valid});
                chk({e.name, ".changed"}, {7'd0, c1},    {7'd0, e.changed});
                chk({e.name, ".hit"},     h1,            e.hit);
            end else begin
                chk({e.name, ".p"},       {4'd0, p4},    {4'd0, e.p});
                chk({e.name, ".p_reg"},   {4'd0, preg4}, {4'd0, e.p_reg});
                chk({e.name, ".valid"},   {7'd0, v4},    {7'd0, e.valid});
                chk({e.name, ".changed"}, {7'd0, c4},    {7'd0, e.changed});
                chk({e.name, ".hit"},     {6'd0, h4},    e.hit);
            end
        end
    end

    // Drive one cycle, then push what the DUT must show after that edge
    task automatic step(input int sel, input logic r, input logic e,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] ep, input logic [3:0] epr, input logic ev,
                        input logic ec, input logic [7:0] eh, input string name);
        exp_t ex;
        @(negedge clk);
        #1;
        if (sel == 1) begin
            rst1 = r; en1 = e; x1 = a[0]; y1 = b[0]; z1 = c[0];
        end else begin
            rst4 = r; en4 = e; x4 = a; y4 = b; z4 = c;
        end
        @(posedge clk);
        ex.sel = sel; ex.p = ep; ex.p_reg = epr; ex.valid = ev;
        ex.changed = ec; ex.hit = eh; ex.name = name;
        q.push_back(ex);
        pushed++;
    endtask

    initial begin
        // ---- 1-lane instance ----
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst1");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst1b");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(1, 1, 0, {3'd0, v[2]}, {3'd0, v[1]}, {3'd0, v[0]},
                 (i == 0) ? 4'd1 : 4'd0, 0, 0, 0, 0, $sformatf("tt%0d", i));
        end
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, "cap000");
        step(1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, "cap001");
        step(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, "hold0");
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, "hold1");
        step(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, "hold2");
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, "hold3");
        step(1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 1, "hold4");
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 2, "cap_a");
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 3, "cap_b");
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "midrst");
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, "release");
        step(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, "post_hold");

        // ---- 4-lane instance, 2-bit counter ----
        step(4, 0, 1, 0, 0, 0, 4'hF, 0, 0, 0, 0, "v_rst");
        step(4, 1, 1, 0, 0, 0, 4'hF, 4'hF, 1, 0, 1, "sat1");
        step(4, 1, 1, 0, 0, 0, 4'hF, 4'hF, 1, 0, 2, "sat2");
        step(4, 1, 1, 0, 0, 0, 4'hF, 4'hF, 1, 0, 3, "sat3");
        step(4, 1, 1, 0, 0, 0, 4'hF, 4'hF, 1, 0, 3, "sat4");
        step(4, 1, 1, 0, 0, 0, 4'hF, 4'hF, 1, 0, 3, "sat5");
        step(4, 1, 1, 4'b0101, 0, 0, 4'b1010, 4'b1010, 1, 1, 3, "v0101");
        step(4, 1, 1, 4'b0101, 4'b0010, 0, 4'b1000, 4'b1000, 1, 1, 3, "v0111");
        step(4, 1, 0, 0, 0, 4'b0001, 4'b1110, 4'b1000, 1, 0, 3, "v_hold");
        step(4, 1, 1, 4'b0101, 4'b0010, 0, 4'b1000, 4'b1000, 1, 0, 3, "v_same");

        // Bounded drain of the scoreboard
        for (int n = 0; n < 20 && q.size() > 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL drain: popped %0d, required %0d", popped, pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
